// File: rtl/pux_si_pkg.sv
// Shared state, status-code and opcode-field definitions for the PUX
// multi-channel stream interface.
package pux_si_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_REQ  = 2'd2;
  localparam state_t ST_STAT = 2'd3;

  typedef logic [1:0] status_code_t;
  localparam status_code_t CODE_OK       = 2'b00;
  localparam status_code_t CODE_LEN_ERR  = 2'b01;
  localparam status_code_t CODE_MASK_ERR = 2'b10;
  localparam status_code_t CODE_SEQ_ERR  = 2'b11;

  // The status code occupies the two MSBs of the status word.
  function automatic int code_msb(input int dataw);
    return dataw - 1;
  endfunction

  function automatic int code_lsb(input int dataw);
    return dataw - 2;
  endfunction

  function automatic int mask_lsb();
    return 0;
  endfunction

  function automatic int mask_msb(input int nch);
    return nch - 1;
  endfunction

  function automatic int len_lsb(input int nch);
    return nch;
  endfunction

  function automatic int len_msb(input int opcw);
    return opcw - 1;
  endfunction

endpackage

// File: rtl/pux_si_fifo.sv
// Per-channel first-word-fall-through FIFO; the head reads as zero when empty.
module pux_si_fifo #(
  parameter int DATAW = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATAW-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATAW-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pux_si_mc.sv
// PUX multi-channel stream interface: latches an opcode, buffers operands per
// channel, hands them to the arithmetic core and returns one status word.
module pux_si_mc
  import pux_si_pkg::*;
#(
  parameter int OPCW  = 8,
  parameter int DATAW = 16,
  parameter int NCH   = 3,
  parameter int DEPTH = 16
) (
  input  logic                 axis_clk,
  input  logic                 axis_rstn,
  input  logic [OPCW-1:0]      axis_opcode_data,
  input  logic                 axis_opcode_valid,
  output logic                 axis_opcode_ready,
  input  logic [NCH*DATAW-1:0] axis_op_data,
  input  logic [NCH-1:0]       axis_op_valid,
  output logic [NCH-1:0]       axis_op_ready,
  output logic [DATAW-1:0]     axis_status_data,
  output logic                 axis_status_valid,
  input  logic                 axis_status_ready,
  output logic                 stream_request,
  input  logic [NCH-1:0]       core_rd_en,
  output logic [NCH*DATAW-1:0] core_rd_data,
  input  logic                 core_done
);

  localparam int LENW     = OPCW - NCH + 1;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int MSK_LSB  = mask_lsb();
  localparam int MSK_MSB  = mask_msb(NCH);
  localparam int LEN_LSB  = len_lsb(NCH);
  localparam int LEN_MSB  = len_msb(OPCW);
  localparam int CODE_MSB = code_msb(DATAW);
  localparam int CODE_LSB = code_lsb(DATAW);

  state_t                   state, state_n;
  logic [OPCW-1:0]          opcode_q, opcode_n;
  status_code_t             code_q, code_n;
  logic                     seq_err, seq_err_n;
  logic [NCH-1:0][LENW-1:0] cnt, cnt_n;

  logic [NCH-1:0]           mask_q, mask_n, mask_in;
  logic [LENW-1:0]          len_q, len_n, len_in;

  logic [NCH-1:0]           push, pop_ok, pop_bad, leftover, chan_done;
  logic [NCH-1:0]           empty, full;
  logic [NCH-1:0][CW-1:0]   fifo_count;
  logic                     flush;

  logic                     opcode_ready_n, stream_request_n, status_valid_n;
  logic [NCH-1:0]           op_ready_n;
  logic [DATAW-1:0]         status_data_n;

  // Length is one wider than its opcode field so the +1 never wraps.
  assign mask_in = axis_opcode_data[MSK_MSB:MSK_LSB];
  assign len_in  = {1'b0, axis_opcode_data[LEN_MSB:LEN_LSB]} + LENW'(1);
  assign mask_q  = opcode_q[MSK_MSB:MSK_LSB];
  assign len_q   = {1'b0, opcode_q[LEN_MSB:LEN_LSB]} + LENW'(1);

  assign push = axis_op_valid & axis_op_ready & ~full;

  always_comb begin
    state_n   = state;
    opcode_n  = opcode_q;
    code_n    = code_q;
    seq_err_n = seq_err;
    cnt_n     = cnt;
    flush     = 1'b0;
    pop_ok    = '0;
    pop_bad   = '0;
    leftover  = '0;
    chan_done = '0;

    for (int c = 0; c < NCH; c++) begin
      if (state == ST_REQ && core_rd_en[c]) begin
        if (mask_q[c] && !empty[c]) begin
          pop_ok[c] = 1'b1;
        end else begin
          pop_bad[c] = 1'b1;
        end
      end
      // A pop in the same cycle as core_done is applied before the check.
      leftover[c] = (fifo_count[c] != CW'(pop_ok[c]));
    end

    case (state)
      ST_IDLE: begin
        if (axis_opcode_valid && axis_opcode_ready) begin
          opcode_n  = axis_opcode_data;
          cnt_n     = '0;
          seq_err_n = 1'b0;
          if (mask_in == '0) begin
            code_n  = CODE_MASK_ERR;
            state_n = ST_STAT;
          end else if (int'(len_in) > DEPTH) begin
            code_n  = CODE_LEN_ERR;
            state_n = ST_STAT;
          end else begin
            code_n  = CODE_OK;
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        for (int c = 0; c < NCH; c++) begin
          cnt_n[c]     = cnt[c] + LENW'(push[c]);
          chan_done[c] = !mask_q[c] || (cnt_n[c] == len_q);
        end
        if (&chan_done) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        seq_err_n = seq_err || (|pop_bad);
        if (core_done) begin
          if (|leftover) begin
            seq_err_n = 1'b1;
          end
          flush   = 1'b1;
          code_n  = seq_err_n ? CODE_SEQ_ERR : CODE_OK;
          state_n = ST_STAT;
        end
      end
      ST_STAT: begin
        if (axis_status_valid && axis_status_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    mask_n           = opcode_n[MSK_MSB:MSK_LSB];
    len_n            = {1'b0, opcode_n[LEN_MSB:LEN_LSB]} + LENW'(1);
    opcode_ready_n   = (state_n == ST_IDLE);
    stream_request_n = (state_n == ST_REQ);
    status_valid_n   = (state_n == ST_STAT);
    for (int c = 0; c < NCH; c++) begin
      op_ready_n[c] = (state_n == ST_LOAD) && mask_n[c] && (cnt_n[c] < len_n);
    end
    status_data_n = '0;
    if (status_valid_n) begin
      status_data_n[OPCW-1:0]          = opcode_n;
      status_data_n[CODE_MSB:CODE_LSB] = code_n;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state             <= ST_IDLE;
      opcode_q          <= '0;
      code_q            <= CODE_OK;
      seq_err           <= 1'b0;
      cnt               <= '0;
      axis_opcode_ready <= 1'b0;
      axis_op_ready     <= '0;
      stream_request    <= 1'b0;
      axis_status_valid <= 1'b0;
      axis_status_data  <= '0;
    end else begin
      state             <= state_n;
      opcode_q          <= opcode_n;
      code_q            <= code_n;
      seq_err           <= seq_err_n;
      cnt               <= cnt_n;
      axis_opcode_ready <= opcode_ready_n;
      axis_op_ready     <= op_ready_n;
      stream_request    <= stream_request_n;
      axis_status_valid <= status_valid_n;
      axis_status_data  <= status_data_n;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pux_si_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (axis_clk),
      .rst_n     (axis_rstn),
      .push      (push[c]),
      .push_data (axis_op_data[c*DATAW +: DATAW]),
      .pop       (pop_ok[c]),
      .flush     (flush),
      .rd_data   (core_rd_data[c*DATAW +: DATAW]),
      .empty     (empty[c]),
      .full      (full[c]),
      .count     (fifo_count[c])
    );
  end

endmodule

// File: tb/tb_pux_si_mc.sv
// Randomized bench for pux_si_mc against an opcode-level behavioural model.
module tb_pux_si_mc;

  localparam int OPCW  = 8;
  localparam int DATAW = 16;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;

  logic                 axis_clk = 1'b0;
  logic                 axis_rstn;
  logic [OPCW-1:0]      axis_opcode_data;
  logic                 axis_opcode_valid;
  logic                 axis_opcode_ready;
  logic [NCH*DATAW-1:0] axis_op_data;
  logic [NCH-1:0]       axis_op_valid;
  logic [NCH-1:0]       axis_op_ready;
  logic [DATAW-1:0]     axis_status_data;
  logic                 axis_status_valid;
  logic                 axis_status_ready;
  logic                 stream_request;
  logic [NCH-1:0]       core_rd_en;
  logic [NCH*DATAW-1:0] core_rd_data;
  logic                 core_done;

  int checks = 0;
  int errors = 0;

  // Model of buffered operands: per-channel word lists with head/tail indices.
  logic [DATAW-1:0] model_mem [NCH][64];
  int               head [NCH];
  int               tail [NCH];

  always #5 axis_clk = ~axis_clk;

  pux_si_mc #(
    .OPCW  (OPCW),
    .DATAW (DATAW),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .axis_clk          (axis_clk),
    .axis_rstn         (axis_rstn),
    .axis_opcode_data  (axis_opcode_data),
    .axis_opcode_valid (axis_opcode_valid),
    .axis_opcode_ready (axis_opcode_ready),
    .axis_op_data      (axis_op_data),
    .axis_op_valid     (axis_op_valid),
    .axis_op_ready     (axis_op_ready),
    .axis_status_data  (axis_status_data),
    .axis_status_valid (axis_status_valid),
    .axis_status_ready (axis_status_ready),
    .stream_request    (stream_request),
    .core_rd_en        (core_rd_en),
    .core_rd_data      (core_rd_data),
    .core_done         (core_done)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATAW-1:0] exp_status(input logic [OPCW-1:0] op, input bit seq);
    int          len;
    logic [1:0]  code;
    len = int'(op[OPCW-1:NCH]) + 1;
    if (op[NCH-1:0] == '0)  code = 2'b10;
    else if (len > DEPTH)   code = 2'b01;
    else if (seq)           code = 2'b11;
    else                    code = 2'b00;
    return {code, {(DATAW-OPCW-2){1'b0}}, op};
  endfunction

  task automatic drive_idle();
    axis_opcode_data  = '0;
    axis_opcode_valid = 1'b0;
    axis_op_data      = '0;
    axis_op_valid     = '0;
    axis_status_ready = 1'b0;
    core_rd_en        = '0;
    core_done         = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_opc_ready"}, 64'(axis_opcode_ready), 64'd0);
    check_output({tag, "_op_ready"}, 64'(axis_op_ready), 64'd0);
    check_output({tag, "_stat_valid"}, 64'(axis_status_valid), 64'd0);
    check_output({tag, "_stat_data"}, 64'(axis_status_data), 64'd0);
    check_output({tag, "_stream_req"}, 64'(stream_request), 64'd0);
    check_output({tag, "_rd_data"}, 64'(core_rd_data), 64'd0);
  endtask

  task automatic do_reset();
    drive_idle();
    #1 axis_rstn = 1'b0;
    repeat (2) @(negedge axis_clk);
    axis_rstn = 1'b1;
    @(negedge axis_clk);
  endtask

  // One opcode end to end. mode 0: clean drain, 1: one extra pop per enabled
  // channel after draining, 2: random pops on any channel and random early done.
  task automatic run_op(input logic [OPCW-1:0] op, input int mode, input int hold);
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   rdy_exp;
    logic [NCH-1:0]   vld;
    logic [NCH-1:0]   en;
    logic [DATAW-1:0] word [NCH];
    logic [DATAW-1:0] st;
    int               len;
    int               pushed [NCH];
    int               cyc;
    int               rem_after;
    bit               seq;
    bit               err_op;
    bit               finished;
    bit               all_empty;
    bit               extra;
    bit               d;

    mask = op[NCH-1:0];
    len  = int'(op[OPCW-1:NCH]) + 1;
    for (int c = 0; c < NCH; c++) begin
      head[c]   = 0;
      tail[c]   = 0;
      pushed[c] = 0;
    end
    seq    = 1'b0;
    err_op = (mask == '0) || (len > DEPTH);

    check_output("opc_ready_idle", 64'(axis_opcode_ready), 64'd1);
    axis_opcode_data  = op;
    axis_opcode_valid = 1'b1;
    @(negedge axis_clk);
    axis_opcode_valid = 1'b0;
    axis_opcode_data  = OPCW'($urandom);
    check_output("opc_ready_drop", 64'(axis_opcode_ready), 64'd0);

    if (!err_op) begin
      cyc = 0;
      forever begin
        for (int c = 0; c < NCH; c++) begin
          rdy_exp[c] = mask[c] && (pushed[c] < len);
        end
        if (rdy_exp == '0) break;
        check_output("op_ready", 64'(axis_op_ready), 64'(rdy_exp));
        check_output("load_stream_req", 64'(stream_request), 64'd0);
        if (cyc > 300) begin
          check_output("load_timeout", 64'd1, 64'd0);
          do_reset();
          return;
        end
        cyc++;
        for (int c = 0; c < NCH; c++) begin
          vld[c]  = mask[c] ? 1'($urandom_range(0, 1)) : 1'b1;
          word[c] = DATAW'($urandom);
          axis_op_data[c*DATAW +: DATAW] = word[c];
        end
        axis_op_valid = vld;
        @(negedge axis_clk);
        for (int c = 0; c < NCH; c++) begin
          if (vld[c] && rdy_exp[c]) begin
            model_mem[c][tail[c]] = word[c];
            tail[c]++;
            pushed[c]++;
          end
        end
      end
      axis_op_valid = '0;
      check_output("req_op_ready", 64'(axis_op_ready), 64'd0);

      cyc      = 0;
      finished = 1'b0;
      extra    = (mode == 1);
      while (!finished) begin
        check_output("req_stream_req", 64'(stream_request), 64'd1);
        for (int c = 0; c < NCH; c++) begin
          check_output("rd_data", 64'(core_rd_data[c*DATAW +: DATAW]),
                       64'((head[c] < tail[c]) ? model_mem[c][head[c]] : '0));
        end
        if (cyc > 300) begin
          check_output("req_timeout", 64'd1, 64'd0);
          do_reset();
          return;
        end
        cyc++;
        en        = '0;
        d         = 1'b0;
        all_empty = 1'b1;
        rem_after = 0;
        for (int c = 0; c < NCH; c++) begin
          if (head[c] < tail[c]) begin
            all_empty = 1'b0;
            en[c]     = 1'($urandom_range(0, 1));
            rem_after += tail[c] - head[c] - int'(en[c]);
          end
        end
        if (mode == 2) begin
          en = NCH'($urandom);
          d  = ($urandom_range(0, 7) == 0);
        end else if (!all_empty) begin
          d = (mode == 0) && (rem_after == 0) && ($urandom_range(0, 1) == 1);
        end else if (extra) begin
          en    = mask;
          extra = 1'b0;
        end else begin
          d = 1'b1;
        end
        core_rd_en = en;
        core_done  = d;
        @(negedge axis_clk);
        core_rd_en = '0;
        core_done  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          if (en[c]) begin
            if (mask[c] && head[c] < tail[c]) head[c]++;
            else seq = 1'b1;
          end
        end
        if (d) begin
          for (int c = 0; c < NCH; c++) begin
            if (head[c] < tail[c]) seq = 1'b1;
          end
          finished = 1'b1;
        end
      end
    end

    st = exp_status(op, seq);
    check_output("stat_stream_req", 64'(stream_request), 64'd0);
    check_output("stat_op_ready", 64'(axis_op_ready), 64'd0);
    check_output("stat_valid", 64'(axis_status_valid), 64'd1);
    check_output("stat_data", 64'(axis_status_data), 64'(st));
    check_output("stat_rd_data", 64'(core_rd_data), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge axis_clk);
      check_output("hold_valid", 64'(axis_status_valid), 64'd1);
      check_output("hold_data", 64'(axis_status_data), 64'(st));
      check_output("hold_opc_ready", 64'(axis_opcode_ready), 64'd0);
    end
    axis_status_ready = 1'b1;
    @(negedge axis_clk);
    axis_status_ready = 1'b0;
    check_output("after_stat_valid", 64'(axis_status_valid), 64'd0);
    check_output("after_stat_opc_ready", 64'(axis_opcode_ready), 64'd1);
  endtask

  initial begin
    drive_idle();
    axis_rstn = 1'b1;
    #2 axis_rstn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge axis_clk);
    axis_rstn = 1'b1;
    #1 check_output("opc_ready_pre_edge", 64'(axis_opcode_ready), 64'd0);
    @(negedge axis_clk);
    check_output("opc_ready_post_edge", 64'(axis_opcode_ready), 64'd1);

    run_op(8'h17, 0, 0);
    run_op(8'h87, 0, 0);
    run_op(8'h18, 0, 1);
    run_op(8'h80, 0, 0);
    run_op(8'h09, 1, 0);
    run_op(8'h1F, 0, 10);

    // Abort an opcode partway through loading.
    axis_opcode_data  = 8'h1F;
    axis_opcode_valid = 1'b1;
    @(negedge axis_clk);
    axis_opcode_valid = 1'b0;
    repeat (2) begin
      check_output("abort_op_ready", 64'(axis_op_ready), 64'(3'b111));
      axis_op_valid = 3'b111;
      axis_op_data  = (NCH*DATAW)'({$urandom, $urandom});
      @(negedge axis_clk);
    end
    axis_op_valid = '0;
    #2 axis_rstn = 1'b0;
    #1 check_reset_outputs("abort");
    drive_idle();
    @(negedge axis_clk);
    axis_rstn = 1'b1;
    @(negedge axis_clk);
    check_output("abort_recover_ready", 64'(axis_opcode_ready), 64'd1);
    run_op(8'h1B, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(OPCW'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pux_si_mc.md
# pux_si_mc

Multi-channel, parametrised successor of the PUX stream interface. Accepts one opcode per operation over AXI-Stream and buffers a per-opcode number of operand words from up to NCH operand streams (A, B, M, … channels) into per-channel FIFOs. It then raises `stream_request` while the arithmetic core drains the buffers, and returns one status word per opcode. It sits between the DMA/stream fabric and the PUX arithmetic core.

## Interface
- `OPCW`, 8, opcode width; `OPCW > NCH`.
- `DATAW`, 16, operand/status word width; `DATAW >= OPCW+2`.
- `NCH`, 3, number of operand channels; channel 0 = A, 1 = B, 2 = M.
- `DEPTH`, 16, words per channel FIFO; power of 2.
- `axis_clk` in 1: single clock; all logic on its rising edge.
- `axis_rstn` in 1: asynchronous, active-low reset.
- `axis_opcode_data` in OPCW; `axis_opcode_valid` in 1; `axis_opcode_ready` out 1.
- `axis_op_data` in NCH*DATAW: channel c occupies bits [c*DATAW +: DATAW].
- `axis_op_valid` in NCH; `axis_op_ready` out NCH: per-channel handshakes.
- `axis_status_data` out DATAW; `axis_status_valid` out 1; `axis_status_ready` in 1.
- `stream_request` out 1: buffers are loaded; the core may consume.
- `core_rd_en` in NCH: pops the FIFO head of channel c.
- `core_rd_data` out NCH*DATAW: FIFO heads, first-word-fall-through; 0 when empty.
- `core_done` in 1: single-cycle pulse; the core has finished.

## Operation
- Opcode fields: `mask = opcode[NCH-1:0]` selects the enabled channels. `len = opcode[OPCW-1:NCH] + 1` is the word count per enabled channel, computed at width OPCW-NCH+1 so there is no wrap.
- FSM states are IDLE, LOAD, REQ and STAT.
- IDLE: `axis_opcode_ready`=1. On opcode handshake, latch the opcode.
  - If `mask==0`: status code MASK_ERR (2'b10), go to STAT.
  - Else if `len>DEPTH`: status code LEN_ERR (2'b01), go to STAT.
  - Mask is checked first.
  - Else go to LOAD.
- LOAD: `axis_op_ready[c]` = `mask[c]` && `cnt[c] < len`. Each handshake pushes the word and increments `cnt[c]`.
  - Disabled channels are never ready.
  - When every enabled channel has `cnt == len`, go to REQ.
- REQ: `stream_request`=1. Pops on enabled, non-empty FIFOs advance the head.
  - A pop on an empty or disabled FIFO is ignored and sets a sticky `seq_err`.
  - On `core_done`: if any FIFO is non-empty, set `seq_err`. Flush all FIFOs and go to STAT with code SEQ_ERR (2'b11) if `seq_err`, else OK (2'b00).
- STAT: `axis_status_valid`=1 and `axis_status_data` = {code, zeros, opcode}, with the code in [DATAW-1:DATAW-2] and the opcode in [OPCW-1:0]. Data is held stable until the handshake; the handshake goes to IDLE.
- `core_done` outside REQ is ignored. `core_rd_en` outside REQ is ignored and sets no flag.

## Timing
- Reset values: every output is 0, FSM in IDLE, all FIFOs empty, counters cleared, flags cleared. `axis_opcode_ready` rises on the first rising edge after `axis_rstn` deasserts.
- All control outputs are registered. `core_rd_data` is the FIFO head and updates the cycle after a pop.
- Opcode handshake at edge N: `axis_opcode_ready` is 0 from N+1. In LOAD, `axis_op_ready` is valid from N+1. On an error opcode, `axis_status_valid` is 1 from N+1.
- Last operand handshake at edge N: `stream_request`=1 from N+1. `axis_op_ready` is 0 from N+1.
- `core_done` at edge N: `stream_request`=0 and `axis_status_valid`=1 from N+1.
- Status handshake at edge N: `axis_opcode_ready`=1 from N+1. Minimum turnaround is one cycle.
- Simultaneous pop and `core_done` in the same cycle: the pop is applied first, then the leftover check.
- Asserting `axis_rstn` low at any time immediately returns to the reset state and drops in-flight data. No status word is produced for an aborted opcode.

## Structure
- Package `pux_si_pkg` holds:
  - the FSM state enum;
  - the status code constants OK, LEN_ERR, MASK_ERR, SEQ_ERR;
  - the status code bit positions;
  - the opcode field split helpers (mask/len LSB, MSB).
- Sub-module `pux_si_fifo` (DATAW, DEPTH): synchronous FWFT FIFO with push, pop, flush, empty, full and count. It is instantiated NCH times with a generate loop. The top level holds the FSM, counters and status.

## Test plan
- Opcode 8'h17 (len 3, mask 7): 3 words each on A/B/M (0x1111…) → `stream_request`=1 one cycle after the last push. The core pops 3 per channel in order, then `core_done` → status 16'h0017.
- Opcode 8'h87 (len 17 > DEPTH 16) → no `axis_op_ready`, status 16'h4087 the next cycle.
- Opcode 8'h18 (mask 0) → status 16'h8018; opcode 8'h80 (mask 0, len 17) → 16'h8080, confirming mask priority.
- Opcode 8'h09 (len 2, mask A only): B/M valid held high stay unready. The core pops A 3 times, then done → status 16'hC009.
- Opcode 8'h1F, then `axis_status_ready` held low 10 cycles → status stable and `axis_opcode_ready`=0 throughout; released → IDLE the next cycle.
- `axis_rstn` pulsed low mid-LOAD after 2 of 4 words → all outputs 0 at once. The next opcode 8'h1B runs cleanly to status 16'h001B.
